// File: rtl/blinky_pkg.sv
// Shared constants and types for the blinky cart.
// Holds the pattern-mode width/type consumed by both switch_conditioner and
// blinky, plus the default debounce length (10 ms at 125 MHz).
package blinky_pkg;

   localparam int unsigned MODE_W                  = 2;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1250000;

   typedef logic [MODE_W-1:0] mode_t;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchroniser chain, debounce counter and edge pulses.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   raw_in     : asynchronous switch input
//   level      : debounced level
//   rise, fall : one-cycle registered pulses on level 0->1 / 1->0
module debounce_channel
   import blinky_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   sync_q;
   logic [CNT_W-1:0]       count;

   assign sync_q = sync_chain[SYNC_STAGES-1];

   // Plain flop chain; bit 0 samples the asynchronous input.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw_in};
      end
   end

   // Accept a new value only after it has differed from level for
   // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync_q == level) begin
            count <= '0;
         end else if (count == CNT_LAST) begin
            count <= '0;
            level <= sync_q;
            rise  <= sync_q;
            fall  <= ~sync_q;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/switch_conditioner.sv
// Conditions the raw board switches for the LED logic and keeps the
// pattern-mode register: switch 0 steps the mode, switch 1 clears it.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   sw_in        : raw asynchronous switches
//   sw_level     : debounced levels
//   sw_rise/fall : one-cycle pulses on debounced edges
//   mode         : current pattern mode
//   mode_changed : one-cycle pulse in the cycle mode takes a new value
module switch_conditioner
   import blinky_pkg::*;
#(
   parameter int unsigned NUM_SW          = 2,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_SW-1:0] sw_in,
   output logic [NUM_SW-1:0] sw_level,
   output logic [NUM_SW-1:0] sw_rise,
   output logic [NUM_SW-1:0] sw_fall,
   output logic [MODE_W-1:0] mode,
   output logic              mode_changed
);

   // One independent conditioner per switch.
   for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .raw_in(sw_in[g]),
         .level (sw_level[g]),
         .rise  (sw_rise[g]),
         .fall  (sw_fall[g])
      );
   end

   // Clear has priority over step; clearing an already-zero mode is not a change.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode         <= '0;
         mode_changed <= 1'b0;
      end else begin
         mode_changed <= 1'b0;
         if (sw_rise[1]) begin
            mode         <= '0;
            mode_changed <= (mode != '0);
         end else if (sw_rise[0]) begin
            mode         <= mode + MODE_W'(1);
            mode_changed <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench for switch_conditioner with a short debounce window.
module tb_switch_conditioner;

   localparam int unsigned NSW  = 2;
   localparam int unsigned SYNC = 2;
   localparam int unsigned DEB  = 4;
   localparam int unsigned MW   = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic [NSW-1:0] sw_in;
   logic [NSW-1:0] sw_level, sw_rise, sw_fall;
   logic [MW-1:0]  mode;
   logic           mode_changed;

   always #5 clk = ~clk;

   switch_conditioner #(
      .NUM_SW(NSW), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk), .reset(reset), .sw_in(sw_in),
      .sw_level(sw_level), .sw_rise(sw_rise), .sw_fall(sw_fall),
      .mode(mode), .mode_changed(mode_changed)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: switch values seen through a delay line, a level is
   // accepted once the delayed value has disagreed with it for DEB edges since
   // the last edge where they agreed (or the last acceptance/reset).
   logic [NSW-1:0] dly[$];
   logic [NSW-1:0] m_level, m_rise, m_fall;
   logic [MW-1:0]  m_mode;
   logic           m_changed;
   int unsigned    last_ok[NSW];
   int unsigned    edge_no = 0;

   task automatic tick();
      logic [NSW-1:0] s, nr, nf;
      @(posedge clk);
      edge_no++;
      if (reset) begin
         dly = {};
         for (int i = 0; i < int'(SYNC); i++) dly.push_back('0);
         m_level = '0; m_rise = '0; m_fall = '0; m_mode = '0; m_changed = 1'b0;
         for (int c = 0; c < int'(NSW); c++) last_ok[c] = edge_no;
      end else begin
         s = dly.pop_front();
         dly.push_back(sw_in);
         m_changed = 1'b0;
         if (m_rise[1]) begin
            m_changed = (m_mode != 0);
            m_mode    = '0;
         end else if (m_rise[0]) begin
            m_mode    = MW'((int'(m_mode) + 1) % (1 << MW));
            m_changed = 1'b1;
         end
         nr = '0; nf = '0;
         for (int c = 0; c < int'(NSW); c++) begin
            if (s[c] == m_level[c]) begin
               last_ok[c] = edge_no;
            end else if (edge_no - last_ok[c] >= DEB) begin
               if (s[c]) nr[c] = 1'b1; else nf[c] = 1'b1;
               m_level[c] = s[c];
               last_ok[c] = edge_no;
            end
         end
         m_rise = nr;
         m_fall = nf;
      end
      #1;
      check("level", 32'(sw_level), 32'(m_level));
      check("rise", 32'(sw_rise), 32'(m_rise));
      check("fall", 32'(sw_fall), 32'(m_fall));
      check("mode", 32'(mode), 32'(m_mode));
      check("mode_changed", 32'(mode_changed), 32'(m_changed));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Counts edges until the selected pulse appears (bounded) and checks the delay.
   task automatic wait_pulse(input string tag, input bit is_fall, input int ch, input int exp_delay);
      int idx = -1;
      for (int k = 1; k <= 20 && idx < 0; k++) begin
         tick();
         if ((is_fall ? sw_fall[ch] : sw_rise[ch]) === 1'b1) idx = k;
      end
      check(tag, 32'(idx), 32'(exp_delay));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int rem[NSW];
      reset = 1'b1;
      sw_in = '0;
      tick(); tick();
      check("reset_outputs", 32'({sw_level, sw_rise, sw_fall, mode, mode_changed}), 32'd0);
      reset = 1'b0;
      run(8);

      // Clean press: rise 6 edges later, mode step on the following edge.
      sw_in[0] = 1'b1;
      wait_pulse("t1_rise_delay", 1'b0, 0, 6);
      check("t1_level", 32'(sw_level[0]), 32'd1);
      tick();
      check("t1_mode", 32'(mode), 32'd1);
      check("t1_changed", 32'(mode_changed), 32'd1);
      run(8);
      sw_in[0] = 1'b0;
      wait_pulse("t1_fall_delay", 1'b1, 0, 6);
      run(8);

      // 3-cycle bounce must be rejected.
      sw_in[0] = 1'b1;
      run(3);
      sw_in[0] = 1'b0;
      run(12);
      check("t2_level", 32'(sw_level[0]), 32'd0);
      check("t2_mode", 32'(mode), 32'd1);

      // Four clean presses from reset: 1,2,3,0.
      do_reset();
      run(4);
      for (int i = 0; i < 4; i++) begin
         sw_in[0] = 1'b1;
         wait_pulse("t3_rise_delay", 1'b0, 0, 6);
         tick();
         check("t3_mode", 32'(mode), 32'((i + 1) % 4));
         check("t3_changed", 32'(mode_changed), 32'd1);
         run(8);
         sw_in[0] = 1'b0;
         wait_pulse("t3_fall_delay", 1'b1, 0, 6);
         run(8);
      end

      // Two steps to mode 2, then simultaneous rises: clear wins.
      for (int i = 0; i < 2; i++) begin
         sw_in[0] = 1'b1; run(12);
         sw_in[0] = 1'b0; run(12);
      end
      check("t4_mode_pre", 32'(mode), 32'd2);
      sw_in = 2'b11;
      wait_pulse("t4_rise1_delay", 1'b0, 1, 6);
      check("t4_both_rise", 32'(sw_rise), 32'd3);
      tick();
      check("t4_mode_clr", 32'(mode), 32'd0);
      check("t4_changed", 32'(mode_changed), 32'd1);
      run(8);
      sw_in = 2'b00; run(12);
      sw_in[1] = 1'b1;
      wait_pulse("t4_rise1b_delay", 1'b0, 1, 6);
      tick();
      check("t4_mode_stay", 32'(mode), 32'd0);
      check("t4_no_change", 32'(mode_changed), 32'd0);
      run(8);
      sw_in[1] = 1'b0; run(12);

      // Reset while sw0's counter is mid-count: fresh full latency afterwards.
      sw_in[0] = 1'b1;
      run(4);
      do_reset();
      check("t5_reset_outputs", 32'({sw_level, sw_rise, sw_fall, mode, mode_changed}), 32'd0);
      wait_pulse("t5_rise_delay", 1'b0, 0, 6);
      tick();
      check("t5_mode", 32'(mode), 32'd1);
      run(8);
      sw_in[0] = 1'b0; run(12);

      // Bounce with widths 1-3 on both channels: outputs must stay quiet.
      for (int c = 0; c < int'(NSW); c++) rem[c] = int'($urandom_range(1, 3));
      for (int i = 0; i < 1000; i++) begin
         for (int c = 0; c < int'(NSW); c++) begin
            rem[c]--;
            if (rem[c] == 0) begin
               sw_in[c] = ~sw_in[c];
               rem[c]   = int'($urandom_range(1, 3));
            end
         end
         tick();
         if (i % 50 == 0)
            check("t6_quiet", 32'({sw_level, sw_rise, sw_fall, mode_changed}), 32'd0);
      end
      sw_in = 2'b11;
      run(20);
      check("t6_settled", 32'(sw_level), 32'd3);

      // Mixed random holds, including lengths that do get accepted.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 5) == 0) sw_in = NSW'($urandom);
         if ($urandom_range(0, 400) == 0) reset = 1'b1;
         tick();
         reset = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Upstream input stage for the blinky cart. It conditions the raw board switches (switches[1:0]) before they reach the LED logic.
- Per switch: synchronises the asynchronous input, debounces it, and outputs a clean level plus one-cycle rise/fall pulses.
- Also holds a small pattern-mode register, stepped by switch 0 and cleared by switch 1. Blinky consumes this register to select its LED pattern.

Parameters:
- NUM_SW, 2: number of switch channels; must be >= 2 (channels 0 and 1 drive the mode logic).
- SYNC_STAGES, 2: synchroniser flop depth; must be >= 2.
- DEBOUNCE_CYCLES, 1250000: consecutive cycles a new synchronised value must persist before it is accepted (10 ms at 125 MHz); must be >= 2.
- MODE_W, 2: width of the mode register.

Ports:
- clk, in, 1: system clock (sys_clock domain).
- reset, in, 1: synchronous, active-high reset.
- sw_in, in, NUM_SW: raw asynchronous switch inputs.
- sw_level, out, NUM_SW: debounced switch levels.
- sw_rise, out, NUM_SW: one-cycle pulse when sw_level goes 0->1.
- sw_fall, out, NUM_SW: one-cycle pulse when sw_level goes 1->0.
- mode, out, MODE_W: current pattern mode.
- mode_changed, out, 1: one-cycle pulse in the cycle mode takes a new value.

Behaviour:
- One clock. Reset is synchronous and active-high.
- All registers are cleared by reset: sync chain, counters, sw_level, sw_rise, sw_fall, mode, mode_changed all = 0.
- Synchroniser: per channel, a SYNC_STAGES-deep flop chain. sync_q is the last stage. No logic sits between the stages.
- Debounce, per channel:
  - counter width = $clog2(DEBOUNCE_CYCLES).
  - sync_q == sw_level: counter <= 0.
  - sync_q != sw_level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync_q != sw_level and counter == DEBOUNCE_CYCLES-1: sw_level <= sync_q, counter <= 0, and the matching rise/fall pulse is registered high for exactly that cycle.
  - Any single cycle with sync_q == sw_level restarts the count. Glitches shorter than DEBOUNCE_CYCLES are never passed through.
- Latency: input held stable from edge N -> sw_level and the pulse change at edge N+SYNC_STAGES+DEBOUNCE_CYCLES.
- sw_rise and sw_fall are never both high on one channel. Pulses are registered outputs, not combinational.
- Mode logic, one cycle after the pulses (registered from sw_rise):
  - sw_rise[1]: mode <= 0; mode_changed = 1 only if mode was != 0.
  - else sw_rise[0]: mode <= mode+1, wrapping modulo 2^MODE_W (3 -> 0); mode_changed = 1.
  - sw_rise[0] and sw_rise[1] in the same cycle: clear wins.
  - Falling edges do not affect mode.
- Reset mid-count: the counter is discarded. A switch held high through reset yields a fresh sw_rise after the full latency following reset release. That rise counts as a mode step.
- Channels >= 2 provide level and pulses only.

Decomposition:
- Shared package blinky_pkg holds MODE_W, the mode_t typedef (logic [MODE_W-1:0]) and DEBOUNCE_CYCLES_DEFAULT. Blinky imports the same package.
- One sub-module, debounce_channel (params SYNC_STAGES, DEBOUNCE_CYCLES; ports clk, reset, raw_in, level, rise, fall). It is instantiated NUM_SW times with a generate loop.
- The mode register stays in the top of switch_conditioner.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
1. Reset -> all outputs 0. sw_in[0] 0->1 at edge 10 and held -> sw_level[0]=1 and sw_rise[0]=1 at edge 16 only; mode=1 with mode_changed=1 at edge 17.
2. sw_in[0] high for 3 cycles then low (bounce) -> sw_level[0] stays 0; no pulses; mode unchanged.
3. Four clean presses of sw0 (each held >= 8 cycles, released >= 8 cycles) -> mode goes 1,2,3,0; four mode_changed pulses; four sw_fall[0] pulses, each 6 cycles after release.
4. mode=2; press sw0 and sw1 so their debounced rises land in the same cycle -> next cycle mode=0 and mode_changed=1. Then press sw1 again -> mode stays 0 and mode_changed stays 0.
5. sw_in[0] held high; assert reset for 1 cycle when the counter is at 2 -> all outputs 0 after reset; sw_rise[0] occurs 6 edges after reset release; mode=1.
6. Random bounce on both channels with pulse widths 1-3 cycles for 1000 cycles, then stable -> no output changes during the bounce. A scoreboard checks that level only changes after 4 consecutive stable synchronised cycles.
